// File: rtl/pulse_sequencer_pkg.sv
// Shared sizes, FSM state encoding and MPL bus slicing for the optical sync-pulse sequencer.
package pulse_sequencer_pkg;

    localparam int unsigned N_CH  = 16;
    localparam int unsigned MPL_W = 5;
    localparam int unsigned IDX_W = $clog2(N_CH);
    localparam int unsigned BUS_W = N_CH * MPL_W;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        PULSE,
        GAP,
        DONE
    } state_t;

    // MPL for channel idx; channel 0 sits in the least-significant field.
    function automatic logic [MPL_W-1:0] mpl_slice(input logic [BUS_W-1:0] bus,
                                                   input logic [IDX_W-1:0] idx);
        return bus[int'(idx)*MPL_W +: MPL_W];
    endfunction

endpackage

// File: rtl/pulse_sequencer_if.sv
// Start/abort/MPL inputs and channel/status outputs of the pulse sequencer.
interface pulse_sequencer_if;
    import pulse_sequencer_pkg::*;

    logic             ps_start;
    logic             ps_abort;
    logic [BUS_W-1:0] mpl_bus;
    logic [N_CH-1:0]  ch_o;
    logic [IDX_W-1:0] cur_ch;
    logic             busy;
    logic             end_flg;

    modport master (
        output ps_start, ps_abort, mpl_bus,
        input  ch_o, cur_ch, busy, end_flg
    );

    modport slave (
        input  ps_start, ps_abort, mpl_bus,
        output ch_o, cur_ch, busy, end_flg
    );

endinterface

// File: rtl/pulse_sequencer_unit_timer.sv
// Loadable down-counter; terminal count is flagged while the count sits at zero.
module unit_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_tc_c
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_tc_c = (r_count == '0);

endmodule

// File: rtl/pulse_sequencer.sv
// Fires the optical sync channels in order, each for MPL x TICK_DIV clocks, with a
// fixed gap between fired channels; pulses end_flg once the whole sequence completes.
module pulse_sequencer
    import pulse_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50,
    parameter int unsigned GAP_UNITS = 1
) (
    input  logic              ps_clk,
    input  logic              ps_rst,
    pulse_sequencer_if.slave  bus
);

    localparam int unsigned MAX_MPL = (1 << MPL_W) - 1;
    localparam int unsigned GAP_EFF = (GAP_UNITS > 0) ? GAP_UNITS : 1;
    localparam int unsigned CNT_W   = $clog2(MAX_MPL * TICK_DIV * GAP_EFF + 1);
    localparam bit          HAS_GAP = (GAP_UNITS > 0);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [BUS_W-1:0] r_mpl_q;
    logic             r_start_d;
    logic [N_CH-1:0]  r_ch_o;
    logic [IDX_W-1:0] r_cur_ch;
    logic             r_busy;
    logic             r_end_flg;

    state_t           w_state_nx;
    logic [IDX_W-1:0] w_idx_nx;
    logic [BUS_W-1:0] w_mpl_nx;
    logic [N_CH-1:0]  w_ch_nx;
    logic [IDX_W-1:0] w_cur_ch_nx;
    logic             w_busy_nx;
    logic             w_end_nx;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_tc;
    logic             w_accept;
    logic             w_last;
    logic [MPL_W-1:0] w_mpl_cur;
    logic [N_CH-1:0]  w_onehot;
    logic [CNT_W-1:0] w_pulse_ld;
    logic [CNT_W-1:0] w_gap_ld;

    assign w_accept   = bus.ps_start & ~r_start_d & (r_state == IDLE);
    assign w_mpl_cur  = mpl_slice(r_mpl_q, r_idx);
    assign w_last     = (r_idx == IDX_W'(N_CH - 1));
    assign w_onehot   = N_CH'(1) << r_idx;
    assign w_pulse_ld = CNT_W'(w_mpl_cur) * CNT_W'(TICK_DIV) - CNT_W'(1);
    assign w_gap_ld   = CNT_W'(GAP_EFF * TICK_DIV - 1);

    unit_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (ps_clk),
        .rst        (ps_rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc_c     (w_tc)
    );

    // State, snapshot and output registers.
    always_ff @(posedge ps_clk or posedge ps_rst) begin
        if (ps_rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_mpl_q   <= '0;
            r_start_d <= 1'b1;
            r_ch_o    <= '0;
            r_cur_ch  <= '0;
            r_busy    <= 1'b0;
            r_end_flg <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_idx     <= w_idx_nx;
            r_mpl_q   <= w_mpl_nx;
            r_start_d <= bus.ps_start;
            r_ch_o    <= w_ch_nx;
            r_cur_ch  <= w_cur_ch_nx;
            r_busy    <= w_busy_nx;
            r_end_flg <= w_end_nx;
        end
    end

    // Next-state and next-output logic; abort overrides everything.
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_mpl_nx   = r_mpl_q;
        w_ch_nx    = '0;
        w_busy_nx  = r_busy;
        w_end_nx   = 1'b0;
        w_load     = 1'b0;
        w_load_val = '0;

        if (bus.ps_abort) begin
            w_state_nx = IDLE;
            w_idx_nx   = '0;
            w_busy_nx  = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_busy_nx = 1'b0;
                    if (w_accept) begin
                        w_state_nx = SELECT;
                        w_idx_nx   = '0;
                        w_mpl_nx   = bus.mpl_bus;
                        w_busy_nx  = 1'b1;
                    end
                end
                SELECT: begin
                    if (w_mpl_cur != '0) begin
                        w_load     = 1'b1;
                        w_load_val = w_pulse_ld;
                        w_ch_nx    = w_onehot;
                        w_state_nx = PULSE;
                    end else if (w_last) begin
                        w_state_nx = DONE;
                    end else begin
                        w_idx_nx = r_idx + IDX_W'(1);
                    end
                end
                PULSE: begin
                    if (!w_tc) begin
                        w_ch_nx = w_onehot;
                    end else if (HAS_GAP && !w_last) begin
                        w_load     = 1'b1;
                        w_load_val = w_gap_ld;
                        w_state_nx = GAP;
                    end else if (w_last) begin
                        w_state_nx = DONE;
                    end else begin
                        w_idx_nx   = r_idx + IDX_W'(1);
                        w_state_nx = SELECT;
                    end
                end
                GAP: begin
                    if (w_tc) begin
                        w_idx_nx   = r_idx + IDX_W'(1);
                        w_state_nx = SELECT;
                    end
                end
                DONE: begin
                    // busy is held through the end_flg cycle and drops one clock later
                    w_end_nx   = 1'b1;
                    w_idx_nx   = '0;
                    w_state_nx = IDLE;
                end
                default: begin
                    w_state_nx = IDLE;
                    w_idx_nx   = '0;
                end
            endcase
        end

        w_cur_ch_nx = (w_state_nx == IDLE) ? '0 : w_idx_nx;
    end

    assign bus.ch_o    = r_ch_o;
    assign bus.cur_ch  = r_cur_ch;
    assign bus.busy    = r_busy;
    assign bus.end_flg = r_end_flg;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer at TICK_DIV=4, GAP_UNITS=1; j counts clocks after the accepting edge.
module tb_pulse_sequencer;
    import pulse_sequencer_pkg::*;

    logic ps_clk = 1'b0;
    logic ps_rst = 1'b1;

    pulse_sequencer_if ps_if ();

    pulse_sequencer #(.TICK_DIV(4), .GAP_UNITS(1)) dut (
        .ps_clk (ps_clk),
        .ps_rst (ps_rst),
        .bus    (ps_if)
    );

    always #5 ps_clk = ~ps_clk;

    int n_chk = 0;
    int n_err = 0;

    int              width   [N_CH];
    int              first_j [N_CH];
    int              oh_err, end_cnt, end_j, busy_low_j;
    logic [N_CH-1:0] ch_j0, last_ch;
    logic            busy_j0;
    logic [BUS_W-1:0] mv;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic set_t2();
        mv = '0;
        mv[4:0]   = 5'd1;
        mv[9:5]   = 5'd3;
        mv[79:75] = 5'd1;
        ps_if.mpl_bus = mv;
    endtask

    // Falling then rising start; returns right after the accepting posedge.
    task automatic start_pulse();
        @(negedge ps_clk);
        ps_if.ps_start = 1'b0;
        @(negedge ps_clk);
        ps_if.ps_start = 1'b1;
        @(posedge ps_clk);
    endtask

    // Samples every clock until busy drops; mode 1 disturbs start/mpl, mode 2 aborts at j=15.
    task automatic capture(input int budget, input int mode);
        bit done = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            width[c]   = 0;
            first_j[c] = -1;
        end
        oh_err = 0; end_cnt = 0; end_j = -1; busy_low_j = -1;
        for (int j = 0; j < budget && !done; j++) begin
            @(negedge ps_clk);
            if (j == 0) begin
                ch_j0   = ps_if.ch_o;
                busy_j0 = ps_if.busy;
            end
            for (int c = 0; c < N_CH; c++) begin
                if (ps_if.ch_o[c]) begin
                    width[c]++;
                    if (first_j[c] < 0) first_j[c] = j;
                end
            end
            if ($countones(ps_if.ch_o) > 1) oh_err++;
            if (ps_if.end_flg) begin
                end_cnt++;
                end_j = j;
            end
            last_ch = ps_if.ch_o;
            if (!ps_if.busy) begin
                busy_low_j = j;
                done = 1'b1;
            end
            if (mode == 1) begin
                if (j == 3)  ps_if.ps_start = 1'b0;
                if (j == 6)  ps_if.mpl_bus  = '1;
                if (j == 12) ps_if.ps_start = 1'b1;
            end
            if (mode == 2 && j == 15) ps_if.ps_abort = 1'b1;
        end
        if (!done) check("timeout_busy_never_fell", 0, 1);
    endtask

    // Expected timeline for MPL1=1, MPL2=3, MPL16=1.
    task automatic check_t2(input string p);
        check({p, "_w0"}, width[0], 4);
        check({p, "_w1"}, width[1], 12);
        check({p, "_w15"}, width[15], 4);
        check({p, "_first0"}, first_j[0], 1);
        check({p, "_first1"}, first_j[1], 10);
        check({p, "_first15"}, first_j[15], 40);
        check({p, "_onehot"}, oh_err, 0);
        check({p, "_end_cnt"}, end_cnt, 1);
        check({p, "_end_j"}, end_j, 45);
        check({p, "_busy_low"}, busy_low_j, 46);
    endtask

    initial begin
        int s;
        ps_if.ps_start = 1'b0;
        ps_if.ps_abort = 1'b0;
        ps_if.mpl_bus  = '0;
        repeat (3) @(negedge ps_clk);
        ps_rst = 1'b0;
        @(negedge ps_clk);
        check("rst_ch_o", int'(ps_if.ch_o), 0);
        check("rst_cur_ch", int'(ps_if.cur_ch), 0);
        check("rst_busy", int'(ps_if.busy), 0);
        check("rst_end_flg", int'(ps_if.end_flg), 0);

        // Test 1: MPL1=2 only; gap after ch0 plus 15 skipped selects precede DONE.
        mv = '0;
        mv[4:0] = 5'd2;
        ps_if.mpl_bus = mv;
        start_pulse();
        capture(200, 0);
        check("t1_ch_j0", int'(ch_j0), 0);
        check("t1_busy_j0", int'(busy_j0), 1);
        check("t1_first0", first_j[0], 1);
        check("t1_w0", width[0], 8);
        s = 0;
        for (int c = 1; c < N_CH; c++) s += width[c];
        check("t1_other_w", s, 0);
        check("t1_end_cnt", end_cnt, 1);
        check("t1_end_j", end_j, 29);
        check("t1_busy_low", busy_low_j, 30);

        // Test 2: three fired channels with skips.
        set_t2();
        start_pulse();
        capture(200, 0);
        check_t2("t2");

        // Test 3: extra start edge and mpl_bus change mid-sequence.
        set_t2();
        start_pulse();
        capture(200, 1);
        check_t2("t3");
        repeat (3) @(negedge ps_clk);
        check("t3_no_retrigger", int'(ps_if.busy), 0);

        // Test 4: abort during ch1, then restart from channel 0.
        set_t2();
        start_pulse();
        capture(200, 2);
        ps_if.ps_abort = 1'b0;
        check("t4_busy_low", busy_low_j, 16);
        check("t4_ch_off", int'(last_ch), 0);
        check("t4_end_cnt", end_cnt, 0);
        check("t4_w1", width[1], 6);
        repeat (3) @(negedge ps_clk);
        check("t4_idle_held", int'(ps_if.busy), 0);
        start_pulse();
        capture(200, 0);
        check_t2("t4r");

        // Test 5: async reset in the gap after ch1 with start held high.
        set_t2();
        start_pulse();
        repeat (24) @(negedge ps_clk);
        check("t5_pre_cur_ch", int'(ps_if.cur_ch), 1);
        check("t5_pre_busy", int'(ps_if.busy), 1);
        #2 ps_rst = 1'b1;
        #1;
        check("t5_rst_busy", int'(ps_if.busy), 0);
        check("t5_rst_cur_ch", int'(ps_if.cur_ch), 0);
        check("t5_rst_ch_o", int'(ps_if.ch_o), 0);
        @(negedge ps_clk);
        #2 ps_rst = 1'b0;
        repeat (4) @(negedge ps_clk);
        check("t5_no_retrigger", int'(ps_if.busy), 0);
        start_pulse();
        capture(200, 0);
        check_t2("t5r");

        // Test 6a: all MPL=31, 124-clock pulses without counter wrap.
        ps_if.mpl_bus = '1;
        start_pulse();
        capture(3000, 0);
        for (int c = 0; c < N_CH; c++) check($sformatf("t6_w%0d", c), width[c], 124);
        check("t6_first15", first_j[15], 1936);
        check("t6_end_j", end_j, 2061);
        check("t6_onehot", oh_err, 0);

        // Test 6b: all MPL=0, only selects then DONE.
        ps_if.mpl_bus = '0;
        start_pulse();
        capture(200, 0);
        s = 0;
        for (int c = 0; c < N_CH; c++) s += width[c];
        check("t6z_w_sum", s, 0);
        check("t6z_end_j", end_j, 17);
        check("t6z_busy_low", busy_low_j, 18);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
